// File: rtl/spi_config_master.sv
// SPI configuration master for the beam-steering slave.
// Shifts mode/address/data frames, single commands or register bursts.
module spi_config_master #(
  parameter int ClockDivider  = 2,
  parameter int CsIdleCycles  = 4,
  parameter int AddressLength = 7,
  parameter int DataLength    = 16,
  parameter int BurstCount    = 5
) (
  input  logic                             MasterClock,
  input  logic                             ResetButton,
  input  logic                             CommandValid,
  output logic                             CommandReady,
  input  logic                             CommandWrite,
  input  logic [AddressLength-1:0]         CommandAddress,
  input  logic [DataLength-1:0]            CommandData,
  input  logic                             BurstValid,
  output logic                             BurstReady,
  input  logic [BurstCount*DataLength-1:0] BurstData,
  output logic                             ResponseValid,
  output logic [DataLength-1:0]            ResponseData,
  output logic                             Busy,
  output logic                             SpiClock,
  output logic                             SpiChipSelect,
  output logic                             SpiDataOut,
  input  logic                             SpiDataIn
);

  localparam int FL = 1 + AddressLength + DataLength;
  localparam int BL = BurstCount * DataLength;
  localparam int BW = $clog2(FL);
  localparam int DW = $clog2(2 * ClockDivider);
  localparam int FW = (BurstCount > 1) ? $clog2(BurstCount) : 1;
  localparam int GW = (CsIdleCycles > 1) ? $clog2(CsIdleCycles) : 1;

  localparam logic [BW-1:0] BitLast   = BW'(FL - 1);
  localparam logic [BW-1:0] DataFirst = BW'(AddressLength + 1);
  localparam logic [DW-1:0] DivHigh   = DW'(ClockDivider);
  localparam logic [DW-1:0] DivLast   = DW'(2 * ClockDivider - 1);
  localparam logic [DW-1:0] TailLast  = DW'(ClockDivider - 1);
  localparam logic [FW-1:0] FrameLast = FW'(BurstCount - 1);
  localparam logic [GW-1:0] GapLast   = GW'(CsIdleCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [FL-1:0]         shift_q, shift_d;
  logic [BL-1:0]         burst_q, burst_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  multi_q, multi_d;
  logic                  read_q, read_d;
  logic [DataLength-1:0] rx_q, rx_d;
  logic                  rvalid_q, rvalid_d;
  logic [DataLength-1:0] rdata_q, rdata_d;

  logic acc_burst;
  logic acc_cmd;
  logic bit_end;
  logic frame_end;
  logic more;
  logic tail_end;
  logic gap_end;
  logic sample;

  assign acc_burst = (state_q == IDLE) && BurstValid
                   && !ResetButton;
  assign acc_cmd   = (state_q == IDLE) && !BurstValid
                   && CommandValid && !ResetButton;
  assign bit_end   = (state_q == SHIFT) && (div_q == DivLast);
  assign frame_end = bit_end && (bit_q == BitLast);
  assign more      = multi_q && (frame_q != FrameLast);
  assign tail_end  = (state_q == TAIL) && (div_q == TailLast);
  assign gap_end   = (state_q == GAP) && (gap_q == GapLast);
  assign sample    = (state_q == SHIFT) && (div_q == DivHigh)
                   && (bit_q >= DataFirst);

  // State register; reset returns straight to IDLE.
  always_ff @(posedge MasterClock) begin
    if (ResetButton) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state sequencing through the frame/tail/gap phases.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (acc_burst || acc_cmd)  state_d = SHIFT;
      SHIFT: if (frame_end && !more)    state_d = TAIL;
      TAIL:  if (tail_end)              state_d = GAP;
      GAP:   if (gap_end)               state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // SPI pins, handshakes and status decoded from the state.
  always_comb begin
    CommandReady  = (state_q == IDLE) && !BurstValid
                  && !ResetButton;
    BurstReady    = (state_q == IDLE) && !ResetButton;
    Busy          = (state_q != IDLE);
    SpiChipSelect = !((state_q == SHIFT) || (state_q == TAIL));
    SpiClock      = (state_q == SHIFT) && (div_q >= DivHigh);
    SpiDataOut    = (state_q == SHIFT) && shift_q[FL-1];
    ResponseValid = rvalid_q;
    ResponseData  = rdata_q;
  end

  // Datapath: frame loading, bit timing, MISO capture, response.
  always_comb begin
    shift_d  = shift_q;
    burst_d  = burst_q;
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    gap_d    = gap_q;
    multi_d  = multi_q;
    read_d   = read_q;
    rx_d     = rx_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        frame_d = '0;
        if (acc_burst) begin
          shift_d = {1'b1, {AddressLength{1'b0}},
                     BurstData[DataLength-1:0]};
          burst_d = BurstData >> DataLength;
          multi_d = 1'b1;
          read_d  = 1'b0;
        end else if (acc_cmd) begin
          shift_d = {CommandWrite, CommandAddress,
                     CommandData};
          multi_d = 1'b0;
          read_d  = !CommandWrite;
        end
      end
      SHIFT: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (sample) rx_d = {rx_q[DataLength-2:0], SpiDataIn};
        if (frame_end) begin
          bit_d = '0;
          if (more) begin
            frame_d = frame_q + 1'b1;
            shift_d = {1'b1,
                       AddressLength'(frame_q + 1'b1),
                       burst_q[DataLength-1:0]};
            burst_d = burst_q >> DataLength;
          end
        end else if (bit_end) begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q << 1;
        end
      end
      TAIL: begin
        div_d = div_q + 1'b1;
        if (tail_end) begin
          div_d = '0;
          gap_d = '0;
          if (read_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rx_q;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
      end
      default: begin
        div_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge MasterClock) begin
    if (ResetButton) begin
      shift_q  <= '0;
      burst_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      gap_q    <= '0;
      multi_q  <= 1'b0;
      read_q   <= 1'b0;
      rx_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      shift_q  <= shift_d;
      burst_q  <= burst_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      gap_q    <= gap_d;
      multi_q  <= multi_d;
      read_q   <= read_d;
      rx_q     <= rx_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: vector table, random commands,
// burst, arbitration and mid-frame reset against a slave model.
module tb_spi_config_master;

  localparam int CD   = 2;
  localparam int GAPC = 4;
  localparam int WIN1 = (24 * 2 + 1) * CD;
  localparam int WINB = (5 * 48 + 1) * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_v = 1'b0;
  logic        cmd_r;
  logic        cmd_w = 1'b0;
  logic [6:0]  cmd_a = '0;
  logic [15:0] cmd_d = '0;
  logic        bst_v = 1'b0;
  logic        bst_r;
  logic [79:0] bst_d = '0;
  logic        rsp_v;
  logic [15:0] rsp_d;
  logic        busy;
  logic        sck;
  logic        csn;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_config_master #(
    .ClockDivider (CD),
    .CsIdleCycles (GAPC)
  ) dut (
    .MasterClock    (clk),
    .ResetButton    (rst),
    .CommandValid   (cmd_v),
    .CommandReady   (cmd_r),
    .CommandWrite   (cmd_w),
    .CommandAddress (cmd_a),
    .CommandData    (cmd_d),
    .BurstValid     (bst_v),
    .BurstReady     (bst_r),
    .BurstData      (bst_d),
    .ResponseValid  (rsp_v),
    .ResponseData   (rsp_d),
    .Busy           (busy),
    .SpiClock       (sck),
    .SpiChipSelect  (csn),
    .SpiDataOut     (mosi),
    .SpiDataIn      (miso)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Bus monitor: MOSI bits, CS windows, gaps, responses.
  bit          mosi_q[$];
  int          win_q[$];
  int          gap_q[$];
  int          cs_run = 0;
  int          hi_run = 0;
  logic        prev_cs = 1'b1;
  int          rv_cnt = 0;
  logic        rv_rise = 1'b0;
  logic [15:0] rv_data = '0;

  always @(posedge sck) mosi_q.push_back(mosi);

  always @(negedge clk) begin
    prev_cs <= csn;
    if (!csn) begin
      cs_run <= cs_run + 1;
      hi_run <= 0;
      if (prev_cs) gap_q.push_back(hi_run);
    end else begin
      hi_run <= hi_run + 1;
      cs_run <= 0;
      if (!prev_cs) win_q.push_back(cs_run);
    end
    if (rsp_v) begin
      rv_cnt  <= rv_cnt + 1;
      rv_rise <= csn && !prev_cs;
      rv_data <= rsp_d;
    end
  end

  // Slave: register file, returns mem[addr] on data bits.
  logic [15:0] mem [128];
  logic [15:0] slave_resp = '0;
  logic [4:0]  sidx = '0;

  always @(negedge sck or posedge csn) begin
    if (csn) sidx <= '0;
    else     sidx <= (sidx == 5'd23) ? 5'd0 : sidx + 5'd1;
  end

  assign miso = (sidx >= 5'd8) ?
                slave_resp[4'(23 - int'(sidx))] : 1'b0;

  function automatic logic [23:0] frame_of(
      input logic w, input int a, input int d);
    return 24'(int'(w) * (1 << 23) + a * (1 << 16) + d);
  endfunction

  function automatic logic [23:0] bits_at(input int s);
    logic [23:0] v = '0;
    for (int i = 0; i < 24; i++)
      v = {v[22:0], mosi_q[s + i]};
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) check({tag, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_cmd_ready(input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cmd_r) break;
    end
    if (!cmd_r) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_cmd(input string tag, input logic w,
                        input logic [6:0] a,
                        input logic [15:0] d,
                        input logic [23:0] ef,
                        input logic [15:0] er);
    int wi, bi, rv0;
    wi  = win_q.size();
    bi  = mosi_q.size();
    rv0 = rv_cnt;
    slave_resp = mem[a];
    wait_cmd_ready(tag);
    cmd_v = 1'b1; cmd_w = w; cmd_a = a; cmd_d = d;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cs_start"}, csn, 0);
    check({tag, "_mode_bit"}, mosi, w);
    wait_idle(tag);
    @(negedge clk); #1;
    check({tag, "_windows"}, win_q.size() - wi, 1);
    if (win_q.size() > wi)
      check({tag, "_cs_low"}, win_q[wi], WIN1);
    check({tag, "_nbits"}, mosi_q.size() - bi, 24);
    if (mosi_q.size() >= bi + 24)
      check({tag, "_frame"}, bits_at(bi), ef);
    check({tag, "_rv_count"}, rv_cnt - rv0, !w);
    if (!w) begin
      check({tag, "_rdata"}, rv_data, er);
      check({tag, "_rv_at_cs_rise"}, rv_rise, 1);
      check({tag, "_rdata_held"}, rsp_d, er);
    end else begin
      mem[a] = d;
    end
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [15:0] d;
    logic [23:0] ef;
    logic [15:0] er;
  } vec_t;

  vec_t vt [6];
  logic [15:0] bv [5];

  initial begin
    int wi, bi, gi, rv0, bad;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[5] = 16'h0500;
    vt[0] = '{1'b1, 7'd0, 16'hABCD, 24'h80ABCD, 16'h0};
    vt[1] = '{1'b0, 7'd5, 16'h0,    24'h050000, 16'h0500};
    vt[2] = '{1'b1, 7'd4, 16'hFFFF, 24'h84FFFF, 16'h0};
    vt[3] = '{1'b0, 7'd4, 16'h0,    24'h040000, 16'hFFFF};
    vt[4] = '{1'b1, 7'd7, 16'h1234, 24'h871234, 16'h0};
    vt[5] = '{1'b0, 7'd7, 16'h0,    24'h070000, 16'h1234};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_r, 0);
    check("rst_bst_ready", bst_r, 0);
    check("rst_cs", csn, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", rsp_v, 0);
    check("rst_rdata", rsp_d, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_r, 1);
    check("post_rst_bst_ready", bst_r, 1);

    for (int i = 0; i < 6; i++)
      do_cmd($sformatf("vec%0d", i), vt[i].w, vt[i].a,
             vt[i].d, vt[i].ef, vt[i].er);

    gi = gap_q.size();
    do_cmd("b2b_w", 1'b1, 7'd9, 16'h1357,
           frame_of(1'b1, 9, 16'h1357), 16'h0);
    do_cmd("b2b_r", 1'b0, 7'd9, 16'h0,
           frame_of(1'b0, 9, 0), 16'h1357);
    if (gap_q.size() >= gi + 2)
      check("b2b_gap", gap_q[gi + 1] >= GAPC, 1);

    for (int i = 0; i < 16; i++) begin
      logic        w;
      logic [6:0]  a;
      logic [15:0] d;
      w = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 127));
      d = 16'($urandom);
      do_cmd($sformatf("rnd%0d", i), w, a, d,
             frame_of(w, int'(a), int'(d)), mem[a]);
    end

    bv[0] = 16'h9BDF; bv[1] = 16'h8ACE; bv[2] = 16'h89AB;
    bv[3] = 16'h4567; bv[4] = 16'hABCD;
    wi = win_q.size(); bi = mosi_q.size();
    gi = gap_q.size(); rv0 = rv_cnt;
    slave_resp = bv[2];
    @(negedge clk);
    bst_d = {bv[4], bv[3], bv[2], bv[1], bv[0]};
    bst_v = 1'b1;
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_a = 7'd2; cmd_d = '0;
    #1;
    check("arb_bst_ready", bst_r, 1);
    check("arb_cmd_ready", cmd_r, 0);
    @(posedge clk); #1;
    bst_v = 1'b0;
    check("arb_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (cmd_r || bst_r) bad++;
    end
    check("arb_ready_while_busy", bad, 0);
    @(posedge clk); #1;
    cmd_v = 1'b0;
    wait_idle("arb");
    @(negedge clk); #1;
    check("burst_windows", win_q.size() - wi, 2);
    if (win_q.size() >= wi + 2) begin
      check("burst_cs_low", win_q[wi], WINB);
      check("arb_cmd_cs_low", win_q[wi + 1], WIN1);
    end
    if (gap_q.size() >= gi + 2)
      check("arb_gap", gap_q[gi + 1] >= GAPC, 1);
    check("burst_nbits", mosi_q.size() - bi, 144);
    if (mosi_q.size() >= bi + 144) begin
      for (int n = 0; n < 5; n++)
        check($sformatf("burst_frame%0d", n),
              bits_at(bi + 24 * n),
              frame_of(1'b1, n, int'(bv[n])));
      check("arb_cmd_frame", bits_at(bi + 120),
            frame_of(1'b0, 2, 0));
    end
    check("arb_rv_count", rv_cnt - rv0, 1);
    check("arb_rdata", rv_data, bv[2]);
    for (int n = 0; n < 5; n++) mem[n] = bv[n];

    bi = mosi_q.size(); rv0 = rv_cnt;
    wait_cmd_ready("rst");
    cmd_v = 1'b1; cmd_w = 1'b1; cmd_a = 7'd3; cmd_d = 16'h5A5A;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mosi_q.size() >= bi + 11) break;
    end
    check("rst_reached_bit10", mosi_q.size() >= bi + 11, 1);
    rst = 1'b1;
    #1;
    check("midrst_cmd_ready", cmd_r, 0);
    @(posedge clk); #1;
    check("midrst_cs", csn, 1);
    check("midrst_sck", sck, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rv", rsp_v, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_no_resp", rv_cnt - rv0, 0);
    do_cmd("after_rst_w", 1'b1, 7'd3, 16'h1234,
           24'h831234, 16'h0);
    do_cmd("after_rst_r", 1'b0, 7'd3, 16'h0,
           24'h030000, 16'h1234);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
